// File: rtl/automat.sv
// automat: Moore pattern detector for the serial sequence 1-0-1.
//
// Ports:
//   clk       - clock, all logic on the rising edge
//   rst_n     - synchronous active-low reset
//   data      - serial input bit, one per clock (X/Z resolves to 0)
//   state_out - current state encoding (registered)
//   out       - high for one cycle while in GOT101 (registered)
//   hit_cnt   - saturating count of detections since reset (registered)
//
// Build option: define AUTOMAT_OVERLAP_EN for overlapping detection
// (GOT101 on 0 -> GOT10); undefined gives non-overlapping (GOT101 on 0 -> IDLE).
module automat #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data,
    output logic [1:0]       state_out,
    output logic             out,
    output logic [CNT_W-1:0] hit_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GOT1   = 2'b01,
        GOT10  = 2'b10,
        GOT101 = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic             out_q;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

    // Next-state decode; an unknown data bit falls through the else branch as 0
    always_comb begin
        state_d   = state_q;
        hit_cnt_d = hit_cnt_q;
        case (state_q)
            IDLE: begin
                if (data == 1'b1) state_d = GOT1;
                else              state_d = IDLE;
            end
            GOT1: begin
                if (data == 1'b1) state_d = GOT1;
                else              state_d = GOT10;
            end
            GOT10: begin
                if (data == 1'b1) state_d = GOT101;
                else              state_d = IDLE;
            end
            GOT101: begin
                if (data == 1'b1) state_d = GOT1;
`ifdef AUTOMAT_OVERLAP_EN
                else              state_d = GOT10;
`else
                else              state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        // Count on entry to GOT101, holding at all-ones
        if (state_d == GOT101 && hit_cnt_q != CNT_MAX) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
    end

    // State, flag and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_q     <= 1'b0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= (state_d == GOT101);
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign state_out = state_q;
    assign out       = out_q;
    assign hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_automat.sv
// tb_automat: scoreboard bench for automat. Two instances share the stimulus:
// u_dut (default CNT_W=8) and u_sat (CNT_W=2) for counter saturation.
module tb_automat;

    logic       clk;
    logic       rst_n;
    logic       data;
    logic [1:0] state_a, state_b;
    logic       out_a, out_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    automat u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .state_out (state_a),
        .out       (out_a),
        .hit_cnt   (cnt_a)
    );

    automat #(.CNT_W(2)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .state_out (state_b),
        .out       (out_b),
        .hit_cnt   (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // State reached from GOT101 on a 0 in this build
`ifdef AUTOMAT_OVERLAP_EN
    localparam logic [1:0] AFT = 2'd2;
    localparam bit         OVL = 1'b1;
`else
    localparam logic [1:0] AFT = 2'd0;
    localparam bit         OVL = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [1:0] st;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Drive one edge's inputs and queue the expected post-edge outputs
    task automatic step(input string name, input logic r, input logic d,
                        input logic [1:0] st, input int c);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        data  = d;
        e.name = name;
        e.st   = st;
        e.c8   = 8'(c);
        e.c2   = (c > 3) ? 2'd3 : 2'(c);
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, compare just after each edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".state"},  int'(state_a), int'(e.st));
            chk({e.name, ".out"},    int'(out_a),   int'(e.st == 2'd3));
            chk({e.name, ".cnt"},    int'(cnt_a),   int'(e.c8));
            chk({e.name, ".state2"}, int'(state_b), int'(e.st));
            chk({e.name, ".out2"},   int'(out_b),   int'(e.st == 2'd3));
            chk({e.name, ".cnt2"},   int'(cnt_b),   int'(e.c2));
        end
    end

    initial begin
        rst_n = 1'b0;
        data  = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held two edges with data toggling, then normal sampling
        step("rst0", 1'b0, 1'b1, 2'd0, 0);
        step("rst1", 1'b0, 1'b0, 2'd0, 0);
        step("rel0", 1'b1, 1'b1, 2'd1, 0);
        step("rel1", 1'b1, 1'b0, 2'd2, 0);
        step("rel2", 1'b1, 1'b0, 2'd0, 0);

        // Single pattern 0,1,0,1,0,0
        step("sp_r", 1'b0, 1'b0, 2'd0, 0);
        step("sp0",  1'b1, 1'b0, 2'd0, 0);
        step("sp1",  1'b1, 1'b1, 2'd1, 0);
        step("sp2",  1'b1, 1'b0, 2'd2, 0);
        step("sp3",  1'b1, 1'b1, 2'd3, 1);
        step("sp4",  1'b1, 1'b0, AFT,  1);
        step("sp5",  1'b1, 1'b0, 2'd0, 1);

        // Overlap stream 1,0,1,0,1,0,1
        step("ov_r", 1'b0, 1'b0, 2'd0, 0);
        step("ov0",  1'b1, 1'b1, 2'd1, 0);
        step("ov1",  1'b1, 1'b0, 2'd2, 0);
        step("ov2",  1'b1, 1'b1, 2'd3, 1);
        step("ov3",  1'b1, 1'b0, AFT,  1);
        step("ov4",  1'b1, 1'b1, OVL ? 2'd3 : 2'd1, OVL ? 2 : 1);
        step("ov5",  1'b1, 1'b0, 2'd2, OVL ? 2 : 1);
        step("ov6",  1'b1, 1'b1, 2'd3, OVL ? 3 : 2);

        // Near misses 1,1,0,0,1,1,0,0
        step("nm_r", 1'b0, 1'b0, 2'd0, 0);
        step("nm0",  1'b1, 1'b1, 2'd1, 0);
        step("nm1",  1'b1, 1'b1, 2'd1, 0);
        step("nm2",  1'b1, 1'b0, 2'd2, 0);
        step("nm3",  1'b1, 1'b0, 2'd0, 0);
        step("nm4",  1'b1, 1'b1, 2'd1, 0);
        step("nm5",  1'b1, 1'b1, 2'd1, 0);
        step("nm6",  1'b1, 1'b0, 2'd2, 0);
        step("nm7",  1'b1, 1'b0, 2'd0, 0);

        // Five 1-0-1 patterns: 8-bit counts 1..5, 2-bit counter holds at 3
        step("sat_r", 1'b0, 1'b0, 2'd0, 0);
        for (int k = 0; k < 5; k++) begin
            step("sat_a", 1'b1, 1'b1, 2'd1, k);
            step("sat_b", 1'b1, 1'b0, 2'd2, k);
            step("sat_c", 1'b1, 1'b1, 2'd3, k + 1);
        end

        // Reset while in GOT101, then reset mid-sequence with data=1
        step("r101", 1'b0, 1'b1, 2'd0, 0);
        step("mr0",  1'b1, 1'b1, 2'd1, 0);
        step("mr1",  1'b1, 1'b0, 2'd2, 0);
        step("mr2",  1'b0, 1'b1, 2'd0, 0);
        step("mr3",  1'b1, 1'b0, 2'd0, 0);

        // Unknown data bit resolves as 0 (GOT10 -> IDLE)
        step("x0",   1'b1, 1'b1,  2'd1, 0);
        step("x1",   1'b1, 1'b0,  2'd2, 0);
        step("x2",   1'b1, 1'bx,  2'd0, 0);
        step("x3",   1'b1, 1'b1,  2'd1, 0);

        // Drain: every queued expectation must be consumed within a few edges
        @(negedge clk);
        repeat (4) @(posedge clk);
        #2;
        chk("drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
